// File: rtl/mask_parity_counter.sv
// mask_parity_counter: counts, per mask channel, the samples whose masked
// plaintext/ciphertext parity is even. A run collects 'target' samples,
// then waits in DRAIN while the two-stage parity pipeline empties.
module mask_parity_counter #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_CH     = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [CNT_WIDTH-1:0]         target,
    input  logic [NUM_CH*DATA_WIDTH-1:0] mask_in,
    input  logic [NUM_CH*DATA_WIDTH-1:0] mask_out,
    input  logic                         in_valid,
    input  logic [DATA_WIDTH-1:0]        message,
    input  logic [DATA_WIDTH-1:0]        cipher,
    output logic                         in_ready,
    output logic                         busy,
    output logic                         done,
    output logic [NUM_CH*CNT_WIDTH-1:0]  counts,
    output logic [CNT_WIDTH-1:0]         accepted
);

    // Number of 6-bit groups; the last (LSB-side) group may be short.
    localparam int NGRP = (DATA_WIDTH + 5) / 6;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                       state, next_state;
    logic                         drain_cnt;
    logic [CNT_WIDTH-1:0]         target_q;
    logic [NUM_CH*DATA_WIDTH-1:0] mask_in_q, mask_out_q;
    logic [CNT_WIDTH-1:0]         accepted_q;
    logic [CNT_WIDTH-1:0]         cnt [NUM_CH];

    logic [NGRP-1:0]              grp_c  [NUM_CH];
    logic [NGRP-1:0]              grp_p1 [NUM_CH];
    logic                         vld_p1;
    logic [NUM_CH-1:0]            par_p2;
    logic                         vld_p2;

    logic                         start_run, accept, last_accept;

    // Group parities, group 0 holding the MSBs.
    function automatic logic [NGRP-1:0] group_parity(input logic [DATA_WIDTH-1:0] x);
        logic [NGRP-1:0] g;
        g = '0;
        for (int b = 0; b < DATA_WIDTH; b++) begin
            g[(DATA_WIDTH - 1 - b) / 6] ^= x[b];
        end
        return g;
    endfunction

    assign start_run   = start && (state == IDLE || state == DONE);
    assign accept      = in_valid && in_ready;
    assign last_accept = accept && ((accepted_q + CNT_WIDTH'(1)) == target_q);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: if (start) next_state = (target == '0) ? DONE : RUN;
            RUN:        if (last_accept) next_state = DRAIN;
            DRAIN:      if (drain_cnt) next_state = DONE;
            default:    next_state = IDLE;
        endcase
    end

    // Output decode from state
    always_comb begin
        in_ready = (state == RUN);
        busy     = (state == RUN) || (state == DRAIN);
        done     = (state == DONE);
    end

    // Second-cycle marker for the two-cycle DRAIN
    always_ff @(posedge clk) begin
        if (rst) drain_cnt <= 1'b0;
        else     drain_cnt <= (state == DRAIN) && !drain_cnt;
    end

    // Run parameters are captured only when a run starts
    always_ff @(posedge clk) begin
        if (start_run) begin
            target_q   <= target;
            mask_in_q  <= mask_in;
            mask_out_q <= mask_out;
        end
    end

    // Per-channel masked combination split into group parities
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            grp_c[k] = group_parity((message & mask_in_q[k*DATA_WIDTH +: DATA_WIDTH]) ^
                                    (cipher  & mask_out_q[k*DATA_WIDTH +: DATA_WIDTH]));
        end
    end

    // Stage 1: group parities of the accepted sample
    always_ff @(posedge clk) begin
        if (rst) vld_p1 <= 1'b0;
        else     vld_p1 <= accept;
        for (int k = 0; k < NUM_CH; k++) grp_p1[k] <= grp_c[k];
    end

    // Stage 2: full parity per channel
    always_ff @(posedge clk) begin
        if (rst) vld_p2 <= 1'b0;
        else     vld_p2 <= vld_p1;
        for (int k = 0; k < NUM_CH; k++) par_p2[k] <= ^grp_p1[k];
    end

    // Acceptance and hit counters
    always_ff @(posedge clk) begin
        if (rst || start_run) begin
            accepted_q <= '0;
            for (int k = 0; k < NUM_CH; k++) cnt[k] <= '0;
        end else begin
            if (accept) accepted_q <= accepted_q + CNT_WIDTH'(1);
            if (vld_p2) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    if (!par_p2[k]) cnt[k] <= cnt[k] + CNT_WIDTH'(1);
                end
            end
        end
    end

    // Pack channel counters onto the output bus
    always_comb begin
        counts = '0;
        for (int k = 0; k < NUM_CH; k++) counts[k*CNT_WIDTH +: CNT_WIDTH] = cnt[k];
    end

    assign accepted = accepted_q;

endmodule

// File: doc/mask_parity_counter.md
MASK_PARITY_COUNTER -- requirements
Module: mask_parity_counter

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 64, giving the message, ciphertext and per-channel mask width.
REQ-002 The module SHALL have parameter NUM_CH, default 4, giving the number of independent mask channels.
REQ-003 The module SHALL have parameter CNT_WIDTH, default 32, giving the width of the sample target and of every counter.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 The module SHALL have port start, input, 1 bit: begins a run.
REQ-007 The module SHALL have port target, input, CNT_WIDTH bits: number of samples in the run, latched at start.
REQ-008 The module SHALL have port mask_in, input, NUM_CH*DATA_WIDTH bits: input masks, channel k at [k*DATA_WIDTH +: DATA_WIDTH], latched at start.
REQ-009 The module SHALL have port mask_out, input, NUM_CH*DATA_WIDTH bits: output masks, packed and latched like mask_in.
REQ-010 The module SHALL have port in_valid, input, 1 bit: a sample is presented.
REQ-011 The module SHALL have port message, input, DATA_WIDTH bits: sample plaintext.
REQ-012 The module SHALL have port cipher, input, DATA_WIDTH bits: sample ciphertext.
REQ-013 The module SHALL have port in_ready, output, 1 bit: the module accepts a sample this cycle.
REQ-014 The module SHALL have port busy, output, 1 bit: the module is in RUN or DRAIN.
REQ-015 The module SHALL have port done, output, 1 bit: the module is in DONE and counts are final.
REQ-016 The module SHALL have port counts, output, NUM_CH*CNT_WIDTH bits: per-channel hit counts, channel k at [k*CNT_WIDTH +: CNT_WIDTH].
REQ-017 The module SHALL have port accepted, output, CNT_WIDTH bits: samples accepted in the current run.

Function
REQ-018 For each channel k, the parity p_k SHALL be the XOR-reduction of (message & mask_in_k) XOR (cipher & mask_out_k), using the latched masks.
REQ-019 A sample SHALL be a hit on channel k when p_k = 0, which counts[k] increments by 1.
REQ-020 Pipeline stage 1 SHALL register, per channel, the parities of 6-bit groups taken from the MSB down; a short final group is allowed when DATA_WIDTH is not a multiple of 6.
REQ-021 Pipeline stage 2 SHALL register the XOR of the stage-1 groups as p_k, together with a valid bit.
REQ-022 The counter update SHALL occur on the second edge after the acceptance edge, i.e. at fixed latency 2.
REQ-023 A sample SHALL be accepted on an edge where in_valid=1 and in_ready=1; in_valid while in_ready=0 SHALL be ignored.
REQ-024 The FSM SHALL have states IDLE, RUN, DRAIN and DONE.
REQ-025 In IDLE or DONE with start=1, the module SHALL latch target and the masks, clear counts and accepted to 0, and go to RUN, or go directly to DONE if target=0.
REQ-026 In RUN, in_ready SHALL be 1, and each acceptance SHALL increment accepted.
REQ-027 In RUN, the acceptance that makes accepted equal to target SHALL move the FSM to DRAIN.
REQ-028 DRAIN SHALL last exactly 2 cycles with in_ready=0 and then go to DONE.
REQ-029 In DONE, done SHALL be held at 1 and counts and accepted SHALL stay stable until the next start.
REQ-030 start asserted in RUN or DRAIN SHALL be ignored.
REQ-031 Mask and target input changes outside a start edge SHALL have no effect.
REQ-032 in_ready SHALL be 0 in IDLE, DRAIN and DONE.
REQ-033 Gaps with in_valid=0 during RUN SHALL insert bubbles with no counter change.
REQ-034 No counter can exceed target, so no wrap SHALL occur; target = 2^CNT_WIDTH-1 SHALL be supported.
REQ-035 When NUM_CH=1, behaviour SHALL be identical per channel.

Reset
REQ-036 When rst=1 at an edge, the module SHALL enter IDLE, clear every pipeline valid, and set counts, accepted, in_ready, busy and done to 0; rst SHALL take priority over start and over acceptance.
REQ-037 A reset during RUN or DRAIN SHALL discard all in-flight samples, and no counter update from them SHALL occur after the reset.

Verification
REQ-038 Scenario: rst, then start with target=4, mask_in ch0=64'h1, all other masks 0, messages 0,1,2,3 back-to-back -> in_ready drops on the 4th acceptance, done=1 three cycles after the last acceptance, ch0=2, ch1..3=4, accepted=4.
REQ-039 Scenario: mask_in ch0=mask_out ch0=64'hFFFF_FFFF_FFFF_FFFF, message=cipher -> every sample is a hit, so ch0 equals target.
REQ-040 Scenario: same stimulus as REQ-038 but with in_valid low on alternate cycles -> identical final counts; busy=1 throughout.
REQ-041 Scenario: start with target=0 -> done=1 on the next cycle with counts all 0, and in_ready never asserts.
REQ-042 Scenario: rst asserted after 2 acceptances in RUN -> all outputs 0 on the next edge and no later count change; a following start with target=1 completes normally.
REQ-043 Scenario: start pulsed in RUN -> ignored; start pulsed in DONE -> counts clear and a new run begins.
